// File: rtl/line_mem_pkg.sv
// Shared definitions for the dual-port line memory.
//  - port_state_e : per-port handshake FSM states (IDLE / WAIT / RESP)
//  - clog2        : ceiling log2, used for all derived widths
//  - LINE_OFF_W   : word-offset width inside a line for the default 4-word line
package line_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } port_state_e;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int LINE_WORDS_DEF = 4;
    localparam int LINE_OFF_W     = clog2(LINE_WORDS_DEF);

endpackage

// File: rtl/line_mem_port_ctrl.sv
// req/ready/valid handshake controller for one memory port.
// Ports:
//  clk, reset_n : clock, asynchronous active-low reset
//  req          : request from the client
//  ready        : registered; high in IDLE and RESP
//  valid        : registered; high for the single RESP cycle
//  accept       : req && ready, the edge at which the array is accessed
//  load         : high in the cycle before RESP, loads the output data register
module line_mem_port_ctrl
    import line_mem_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    output logic ready,
    output logic valid,
    output logic accept,
    output logic load
);

    localparam int CNT_W = (LATENCY > 1) ? clog2(LATENCY) : 1;

    port_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;

    assign accept = req && ready_q;
    assign ready  = ready_q;
    assign valid  = valid_q;

    // State, counter and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic. cnt holds the number of WAIT cycles still to spend;
    // the FSM leaves WAIT on the cycle the count runs out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so ready/valid come straight from flops.
    always_comb begin
        ready_d = (state_d != ST_WAIT);
        valid_d = (state_d == ST_RESP);
        load    = valid_d;
    end

endmodule

// File: rtl/line_mem_dp.sv
// Parametrised dual-port line memory.
// Ports:
//  clk, reset_n                 : clock, asynchronous active-low reset
//  i_req/i_addr                 : port I line read request (read-only)
//  i_ready/i_valid/i_rdata      : port I handshake and read line
//  d_req/d_we/d_addr            : port D request, 1 = write
//  d_wdata/d_wmask              : port D write line and per-word enables
//  d_ready/d_valid/d_rdata      : port D handshake; rdata is 0 on write acks
// Word k of a line sits at bits [k*WORD_W +: WORD_W]. Array contents survive reset.
module line_mem_dp
    import line_mem_pkg::*;
#(
    parameter int    WORD_W      = 16,
    parameter int    ADDR_W      = 16,
    parameter int    DEPTH_WORDS = 256,
    parameter int    LINE_WORDS  = 4,
    parameter int    LATENCY     = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         i_ready,
    output logic                         i_valid,
    output logic [LINE_WORDS*WORD_W-1:0] i_rdata,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [LINE_WORDS*WORD_W-1:0] d_wdata,
    input  logic [LINE_WORDS-1:0]        d_wmask,
    output logic                         d_ready,
    output logic                         d_valid,
    output logic [LINE_WORDS*WORD_W-1:0] d_rdata
);

    localparam int OFF_W     = clog2(LINE_WORDS);
    localparam int NUM_LINES = DEPTH_WORDS / LINE_WORDS;
    localparam int IDX_W     = clog2(NUM_LINES);
    localparam int MEM_AW    = clog2(DEPTH_WORDS);
    localparam int LINE_W    = LINE_WORDS * WORD_W;

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    logic              i_accept_s, i_load_s, d_accept_s, d_load_s;
    logic [IDX_W-1:0]  i_idx_s, d_idx_s;
    logic [MEM_AW-1:0] i_base_s, d_base_s;
    logic              fwd_s;
    logic [LINE_W-1:0] i_line_s, d_line_s, d_line_eff_s;
    logic [LINE_W-1:0] i_cap_q, i_cap_d, i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_cap_q, d_cap_d, d_rdata_q, d_rdata_d;
    logic              unused_addr_s;

    line_mem_port_ctrl #(.LATENCY(LATENCY)) u_i_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (i_req),
        .ready   (i_ready),
        .valid   (i_valid),
        .accept  (i_accept_s),
        .load    (i_load_s)
    );

    line_mem_port_ctrl #(.LATENCY(LATENCY)) u_d_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (d_req),
        .ready   (d_ready),
        .valid   (d_valid),
        .accept  (d_accept_s),
        .load    (d_load_s)
    );

    // Offset bits and bits above the array size are dropped, so addresses wrap.
    assign i_idx_s       = i_addr[OFF_W +: IDX_W];
    assign d_idx_s       = d_addr[OFF_W +: IDX_W];
    assign i_base_s      = MEM_AW'(i_idx_s) << OFF_W;
    assign d_base_s      = MEM_AW'(d_idx_s) << OFF_W;
    assign unused_addr_s = ^{i_addr, d_addr};

    // A D write accepted on the same edge as an I read of the same line is forwarded.
    assign fwd_s = d_accept_s && d_we && (d_idx_s == i_idx_s);

    // Masked line write; no reset so committed data survives reset.
    always_ff @(posedge clk) begin
        if (d_accept_s && d_we) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                if (d_wmask[k]) begin
                    mem_q[d_base_s + MEM_AW'(k)] <= d_wdata[k*WORD_W +: WORD_W];
                end
            end
        end
    end

    // Line read for both ports, with write-first merge on port I.
    always_comb begin
        i_line_s = {LINE_W{1'b0}};
        d_line_s = {LINE_W{1'b0}};
        for (int k = 0; k < LINE_WORDS; k++) begin
            d_line_s[k*WORD_W +: WORD_W] = mem_q[d_base_s + MEM_AW'(k)];
            if (fwd_s && d_wmask[k]) begin
                i_line_s[k*WORD_W +: WORD_W] = d_wdata[k*WORD_W +: WORD_W];
            end else begin
                i_line_s[k*WORD_W +: WORD_W] = mem_q[i_base_s + MEM_AW'(k)];
            end
        end
        if (d_we) begin
            d_line_eff_s = {LINE_W{1'b0}};
        end else begin
            d_line_eff_s = d_line_s;
        end
    end

    // Capture at accept; the output register only changes when valid rises,
    // so rdata is stable from one valid to the next.
    always_comb begin
        if (i_accept_s) begin
            i_cap_d = i_line_s;
        end else begin
            i_cap_d = i_cap_q;
        end
        if (d_accept_s) begin
            d_cap_d = d_line_eff_s;
        end else begin
            d_cap_d = d_cap_q;
        end
        if (i_load_s) begin
            i_rdata_d = (LATENCY == 1) ? i_line_s : i_cap_q;
        end else begin
            i_rdata_d = i_rdata_q;
        end
        if (d_load_s) begin
            d_rdata_d = (LATENCY == 1) ? d_line_eff_s : d_cap_q;
        end else begin
            d_rdata_d = d_rdata_q;
        end
    end

    // Capture and output data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i_cap_q   <= {LINE_W{1'b0}};
            d_cap_q   <= {LINE_W{1'b0}};
            i_rdata_q <= {LINE_W{1'b0}};
            d_rdata_q <= {LINE_W{1'b0}};
        end else begin
            i_cap_q   <= i_cap_d;
            d_cap_q   <= d_cap_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule
